mc_ctrl_seq: RTL and testbench

Parametrised multicycle control sequencer; next-generation replacement for the fixed-timing control FSM.
- Consumes the instruction class and flags produced by the instruction decoder.
- Emits the datapath strobes and selects.
- Adds a variable-latency memory valid/ready handshake with timeout, a trap path for undefined instructions and memory timeouts, and a retired-instruction counter.

---
 rtl/mc_ctrl_seq_pkg.sv | 83 ++++++++
 rtl/mc_ctrl_seq_if.sv | 29 ++
 rtl/mc_ctrl_seq_mem_wait_timer.sv | 49 ++++
 rtl/mc_ctrl_seq.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_seq.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_seq_pkg
// Shared definitions for the multicycle control sequencer:
//   - FSM state codes (plain 4-bit localparams so legacy tooling can decode them)
//   - instruction class codes produced by the instruction decoder
//   - datapath select encodings (pc_s, rd_s, w_rdata_s) and trap causes
//   - ctrl_out_t: bundle of every Moore-decoded strobe/select
//   - cls_defined(): true for the instruction classes the sequencer executes
// -----------------------------------------------------------------------------
package mc_ctrl_seq_pkg;

   // FSM state codes
   localparam logic [3:0] ST_FETCH     = 4'd0;
   localparam logic [3:0] ST_DECODE    = 4'd1;
   localparam logic [3:0] ST_EXEC_DP   = 4'd2;
   localparam logic [3:0] ST_WB_ALU    = 4'd3;
   localparam logic [3:0] ST_EXEC_ADDR = 4'd4;
   localparam logic [3:0] ST_MEM_RD    = 4'd5;
   localparam logic [3:0] ST_MEM_WR    = 4'd6;
   localparam logic [3:0] ST_WB_LOAD   = 4'd7;
   localparam logic [3:0] ST_WB_BASE   = 4'd8;
   localparam logic [3:0] ST_BRANCH    = 4'd9;
   localparam logic [3:0] ST_TRAP      = 4'd10;
   localparam logic [3:0] ST_HALT      = 4'd11;

   // Instruction class codes from the decoder
   localparam logic [2:0] CLS_DP  = 3'd0;
   localparam logic [2:0] CLS_CMP = 3'd1;
   localparam logic [2:0] CLS_LDR = 3'd2;
   localparam logic [2:0] CLS_STR = 3'd3;
   localparam logic [2:0] CLS_B   = 3'd4;
   localparam logic [2:0] CLS_BL  = 3'd5;
   localparam logic [2:0] CLS_UND = 3'd7;

   // PC source select
   localparam logic [1:0] PC_SEL_PC4  = 2'b00;
   localparam logic [1:0] PC_SEL_ALU  = 2'b01;
   localparam logic [1:0] PC_SEL_TRAP = 2'b10;

   // Register-file destination select
   localparam logic [1:0] RD_SEL_RD  = 2'b00;
   localparam logic [1:0] RD_SEL_LR  = 2'b01;
   localparam logic [1:0] RD_SEL_RN  = 2'b10;

   // Register-file write data select
   localparam logic [1:0] WD_SEL_C   = 2'b00;
   localparam logic [1:0] WD_SEL_MEM = 2'b01;
   localparam logic [1:0] WD_SEL_PC  = 2'b10;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_UNDEF   = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_s;
      logic       write_ir;
      logic       write_pc;
      logic [1:0] pc_s;
      logic       write_reg;
      logic [1:0] rd_s;
      logic [1:0] w_rdata_s;
      logic       la;
      logic       lb;
      logic       lc;
      logic       lf;
      logic       ld;
      logic       halted;
   } ctrl_out_t;

   // Code 6 is unassigned and is treated like UND.
   function automatic logic cls_defined(input logic [2:0] cls);
      logic ok;
      case (cls)
         CLS_DP, CLS_CMP, CLS_LDR, CLS_STR, CLS_B, CLS_BL: ok = 1'b1;
         default:                                          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mc_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_seq_if
// Memory request/response handshake between the sequencer and memory.
//   mem_req    : request valid, held until mem_ready is seen
//   mem_we     : request is a write
//   mem_addr_s : address select, 0 = PC, 1 = C register
//   mem_ready  : memory completes the current request this cycle
// master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface mc_ctrl_seq_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_s;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_s,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_s,
      output mem_ready
   );
endinterface

// File: rtl/mc_ctrl_seq_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts stalled memory-wait cycles and flags the cycle in which the count
// reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the timer (done never fires).
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : clear the count (state change)
//   inc  : a stalled wait cycle (request pending, no ready)
//   done : combinational, this stalled cycle is the MEM_TIMEOUT-th one
// -----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic done
);

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         assign done = 1'b0;
      end else begin : g_on
         localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
         localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);
         localparam logic [CW-1:0] ONE   = CW'(1'b1);

         logic [CW-1:0] cnt_r;

         // The count never passes LIMIT: done forces the FSM out of the wait state
         assign done = inc && (cnt_r == LIMIT);

         // Wait-cycle counter
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_r <= {CW{1'b0}};
            end else if (clr) begin
               cnt_r <= {CW{1'b0}};
            end else if (inc) begin
               cnt_r <= cnt_r + ONE;
            end else begin
               cnt_r <= cnt_r;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/mc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// mc_ctrl_seq
// Multicycle control sequencer. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB states, driving datapath strobes and selects,
// with a timed memory handshake, a trap path and a retired-instruction counter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ins_class         : decoded instruction class
//   cond_pass         : condition check passed (used in DECODE)
//   S, wb_base        : set-flags bit, load/store base writeback
//   mem               : memory handshake (mc_ctrl_seq_if.master)
//   write_ir/write_pc/pc_s, write_reg/rd_s/w_rdata_s, LA/LB/LC/LF/LD : datapath
//   trap, trap_cause  : sticky trap flag and last cause
//   halted            : in HALT
//   retired_cnt       : completed instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_ctrl_seq
   import mc_ctrl_seq_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          TRAP_RESUME = 1'b1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       ins_class,
   input  logic             cond_pass,
   input  logic             S,
   input  logic             wb_base,
   mc_ctrl_seq_if.master    mem,
   output logic             write_ir,
   output logic             write_pc,
   output logic [1:0]       pc_s,
   output logic             write_reg,
   output logic [1:0]       rd_s,
   output logic [1:0]       w_rdata_s,
   output logic             LA,
   output logic             LB,
   output logic             LC,
   output logic             LF,
   output logic             LD,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             halted,
   output logic [CNT_W-1:0] retired_cnt
);

   logic [3:0]       state_r;
   logic [3:0]       state_nxt_s;
   logic             retire_s;
   logic             trap_go_s;
   logic [1:0]       trap_cause_nxt_s;
   logic             trap_r;
   logic [1:0]       trap_cause_r;
   logic [CNT_W-1:0] retired_cnt_r;
   logic             timer_clr_s;
   logic             timer_inc_s;
   logic             timeout_s;
   ctrl_out_t        out_s;

   // Clearing on every state change means each wait state starts from zero.
   assign timer_clr_s = (state_nxt_s != state_r);
   assign timer_inc_s = out_s.mem_req & ~mem.mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (timer_clr_s),
      .inc  (timer_inc_s),
      .done (timeout_s)
   );

   // Next-state, retire and trap-entry decode
   always_comb begin
      state_nxt_s      = state_r;
      retire_s         = 1'b0;
      trap_go_s        = 1'b0;
      trap_cause_nxt_s = CAUSE_NONE;
      case (state_r)
         ST_FETCH: begin
            if (mem.mem_ready) begin
               state_nxt_s = ST_DECODE;
            end else if (timeout_s) begin
               state_nxt_s      = ST_TRAP;
               trap_go_s        = 1'b1;
               trap_cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            // Undefined traps even when the condition fails
            if (!cls_defined(ins_class)) begin
               state_nxt_s      = ST_TRAP;
               trap_go_s        = 1'b1;
               trap_cause_nxt_s = CAUSE_UNDEF;
            end else if (!cond_pass) begin
               state_nxt_s = ST_FETCH;
               retire_s    = 1'b1;
            end else begin
               case (ins_class)
                  CLS_DP, CLS_CMP:  state_nxt_s = ST_EXEC_DP;
                  CLS_LDR, CLS_STR: state_nxt_s = ST_EXEC_ADDR;
                  CLS_B, CLS_BL:    state_nxt_s = ST_BRANCH;
                  default: begin
                     state_nxt_s      = ST_TRAP;
                     trap_go_s        = 1'b1;
                     trap_cause_nxt_s = CAUSE_UNDEF;
                  end
               endcase
            end
         end
         ST_EXEC_DP: begin
            if (ins_class == CLS_CMP) begin
               state_nxt_s = ST_FETCH;
               retire_s    = 1'b1;
            end else begin
               state_nxt_s = ST_WB_ALU;
            end
         end
         ST_WB_ALU: begin
            state_nxt_s = ST_FETCH;
            retire_s    = 1'b1;
         end
         ST_EXEC_ADDR: begin
            if (ins_class == CLS_STR) begin
               state_nxt_s = ST_MEM_WR;
            end else begin
               state_nxt_s = ST_MEM_RD;
            end
         end
         ST_MEM_RD: begin
            if (mem.mem_ready) begin
               state_nxt_s = ST_WB_LOAD;
            end else if (timeout_s) begin
               state_nxt_s      = ST_TRAP;
               trap_go_s        = 1'b1;
               trap_cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = ST_MEM_RD;
            end
         end
         ST_MEM_WR: begin
            if (mem.mem_ready) begin
               if (wb_base) begin
                  state_nxt_s = ST_WB_BASE;
               end else begin
                  state_nxt_s = ST_FETCH;
                  retire_s    = 1'b1;
               end
            end else if (timeout_s) begin
               state_nxt_s      = ST_TRAP;
               trap_go_s        = 1'b1;
               trap_cause_nxt_s = CAUSE_TIMEOUT;
            end else begin
               state_nxt_s = ST_MEM_WR;
            end
         end
         ST_WB_LOAD: begin
            if (wb_base) begin
               state_nxt_s = ST_WB_BASE;
            end else begin
               state_nxt_s = ST_FETCH;
               retire_s    = 1'b1;
            end
         end
         ST_WB_BASE: begin
            state_nxt_s = ST_FETCH;
            retire_s    = 1'b1;
         end
         ST_BRANCH: begin
            state_nxt_s = ST_FETCH;
            retire_s    = 1'b1;
         end
         ST_TRAP: begin
            if (TRAP_RESUME) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_HALT;
            end
         end
         ST_HALT: begin
            state_nxt_s = ST_HALT;
         end
         default: begin
            // Unreachable encodings recover to a clean fetch
            state_nxt_s = ST_FETCH;
         end
      endcase
   end

   // Moore strobe decode; everything is held low while rst is asserted
   always_comb begin
      out_s = '0;
      if (rst) begin
         out_s = '0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               out_s.mem_req    = 1'b1;
               out_s.mem_addr_s = 1'b0;
               if (mem.mem_ready) begin
                  out_s.write_ir = 1'b1;
                  out_s.write_pc = 1'b1;
                  out_s.pc_s     = PC_SEL_PC4;
               end else begin
                  out_s.write_ir = 1'b0;
               end
            end
            ST_DECODE: begin
               out_s.la = 1'b1;
               out_s.lb = 1'b1;
            end
            ST_EXEC_DP: begin
               out_s.lc = 1'b1;
               out_s.lf = S;
            end
            ST_WB_ALU: begin
               out_s.write_reg = 1'b1;
               out_s.rd_s      = RD_SEL_RD;
               out_s.w_rdata_s = WD_SEL_C;
            end
            ST_EXEC_ADDR: begin
               out_s.lc = 1'b1;
            end
            ST_MEM_RD: begin
               out_s.mem_req    = 1'b1;
               out_s.mem_addr_s = 1'b1;
               out_s.ld         = mem.mem_ready;
            end
            ST_MEM_WR: begin
               out_s.mem_req    = 1'b1;
               out_s.mem_we     = 1'b1;
               out_s.mem_addr_s = 1'b1;
            end
            ST_WB_LOAD: begin
               out_s.write_reg = 1'b1;
               out_s.rd_s      = RD_SEL_RD;
               out_s.w_rdata_s = WD_SEL_MEM;
            end
            ST_WB_BASE: begin
               out_s.write_reg = 1'b1;
               out_s.rd_s      = RD_SEL_RN;
               out_s.w_rdata_s = WD_SEL_C;
            end
            ST_BRANCH: begin
               out_s.write_pc = 1'b1;
               out_s.pc_s     = PC_SEL_ALU;
               if (ins_class == CLS_BL) begin
                  out_s.write_reg = 1'b1;
                  out_s.rd_s      = RD_SEL_LR;
                  out_s.w_rdata_s = WD_SEL_PC;
               end else begin
                  out_s.write_reg = 1'b0;
               end
            end
            ST_TRAP: begin
               out_s.write_pc = 1'b1;
               out_s.pc_s     = PC_SEL_TRAP;
            end
            ST_HALT: begin
               out_s.halted = 1'b1;
            end
            default: begin
               out_s = '0;
            end
         endcase
      end
   end

   // State, sticky trap status and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_FETCH;
         trap_r        <= 1'b0;
         trap_cause_r  <= CAUSE_NONE;
         retired_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         // Trap status is loaded on entry so it is visible during the TRAP cycle
         if (trap_go_s) begin
            trap_r       <= 1'b1;
            trap_cause_r <= trap_cause_nxt_s;
         end
         if (retire_s) begin
            retired_cnt_r <= retired_cnt_r + CNT_W'(1'b1);
         end
      end
   end

   assign mem.mem_req    = out_s.mem_req;
   assign mem.mem_we     = out_s.mem_we;
   assign mem.mem_addr_s = out_s.mem_addr_s;
   assign write_ir       = out_s.write_ir;
   assign write_pc       = out_s.write_pc;
   assign pc_s           = out_s.pc_s;
   assign write_reg      = out_s.write_reg;
   assign rd_s           = out_s.rd_s;
   assign w_rdata_s      = out_s.w_rdata_s;
   assign LA             = out_s.la;
   assign LB             = out_s.lb;
   assign LC             = out_s.lc;
   assign LF             = out_s.lf;
   assign LD             = out_s.ld;
   assign halted         = out_s.halted;
   assign trap           = trap_r;
   assign trap_cause     = trap_cause_r;
   assign retired_cnt    = retired_cnt_r;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_seq
// Directed bench for mc_ctrl_seq. Two instances share stimulus:
//   dut_a : MEM_TIMEOUT=4, TRAP_RESUME=1
//   dut_h : MEM_TIMEOUT=4, TRAP_RESUME=0
// Strobes are compared as an 18-bit vector laid out as
//   req we as ir wpc pc_s[2] wr rd_s[2] wd_s[2] LA LB LC LF LD halted
// -----------------------------------------------------------------------------
module tb_mc_ctrl_seq;

   localparam logic [2:0] DP  = 3'd0;
   localparam logic [2:0] CMP = 3'd1;
   localparam logic [2:0] LDR = 3'd2;
   localparam logic [2:0] STR = 3'd3;
   localparam logic [2:0] B   = 3'd4;
   localparam logic [2:0] BL  = 3'd5;
   localparam logic [2:0] UND = 3'd7;

   //                                   rq we as ir wp pcs wr rds wds A  B  C  F  D  h
   localparam logic [17:0] O_ZERO   = 18'b0_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_FWAIT  = 18'b1_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_FDONE  = 18'b1_0_0_1_1_00_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_DEC    = 18'b0_0_0_0_0_00_0_00_00_1_1_0_0_0_0;
   localparam logic [17:0] O_EXDP_S = 18'b0_0_0_0_0_00_0_00_00_0_0_1_1_0_0;
   localparam logic [17:0] O_EXC    = 18'b0_0_0_0_0_00_0_00_00_0_0_1_0_0_0;
   localparam logic [17:0] O_WBALU  = 18'b0_0_0_0_0_00_1_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_RDWAIT = 18'b1_0_1_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_RDDONE = 18'b1_0_1_0_0_00_0_00_00_0_0_0_0_1_0;
   localparam logic [17:0] O_MWR    = 18'b1_1_1_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_WBLOAD = 18'b0_0_0_0_0_00_1_00_01_0_0_0_0_0_0;
   localparam logic [17:0] O_WBBASE = 18'b0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
   localparam logic [17:0] O_BR_B   = 18'b0_0_0_0_1_01_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_BR_BL  = 18'b0_0_0_0_1_01_1_01_10_0_0_0_0_0_0;
   localparam logic [17:0] O_TRAP   = 18'b0_0_0_0_1_10_0_00_00_0_0_0_0_0_0;
   localparam logic [17:0] O_HALT   = 18'b0_0_0_0_0_00_0_00_00_0_0_0_0_0_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] ins_class;
   logic       cond_pass;
   logic       s_bit;
   logic       wb_base;
   logic       mem_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_ctrl_seq_if bus_a ();
   mc_ctrl_seq_if bus_h ();
   assign bus_a.mem_ready = mem_ready;
   assign bus_h.mem_ready = mem_ready;

   logic        wir_a, wpc_a, wreg_a, la_a, lb_a, lc_a, lf_a, ld_a, trap_a, halt_a;
   logic [1:0]  pcs_a, rds_a, wds_a, cause_a;
   logic [31:0] cnt_a;
   logic        wir_h, wpc_h, wreg_h, la_h, lb_h, lc_h, lf_h, ld_h, trap_h, halt_h;
   logic [1:0]  pcs_h, rds_h, wds_h, cause_h;
   logic [31:0] cnt_h;

   mc_ctrl_seq #(.MEM_TIMEOUT(4), .TRAP_RESUME(1'b1), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .ins_class(ins_class), .cond_pass(cond_pass),
      .S(s_bit), .wb_base(wb_base), .mem(bus_a),
      .write_ir(wir_a), .write_pc(wpc_a), .pc_s(pcs_a), .write_reg(wreg_a),
      .rd_s(rds_a), .w_rdata_s(wds_a), .LA(la_a), .LB(lb_a), .LC(lc_a),
      .LF(lf_a), .LD(ld_a), .trap(trap_a), .trap_cause(cause_a),
      .halted(halt_a), .retired_cnt(cnt_a)
   );

   mc_ctrl_seq #(.MEM_TIMEOUT(4), .TRAP_RESUME(1'b0), .CNT_W(32)) dut_h (
      .clk(clk), .rst(rst), .ins_class(ins_class), .cond_pass(cond_pass),
      .S(s_bit), .wb_base(wb_base), .mem(bus_h),
      .write_ir(wir_h), .write_pc(wpc_h), .pc_s(pcs_h), .write_reg(wreg_h),
      .rd_s(rds_h), .w_rdata_s(wds_h), .LA(la_h), .LB(lb_h), .LC(lc_h),
      .LF(lf_h), .LD(ld_h), .trap(trap_h), .trap_cause(cause_h),
      .halted(halt_h), .retired_cnt(cnt_h)
   );

   logic [17:0] vec_a;
   logic [17:0] vec_h;
   assign vec_a = {bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr_s, wir_a, wpc_a, pcs_a,
                   wreg_a, rds_a, wds_a, la_a, lb_a, lc_a, lf_a, ld_a, halt_a};
   assign vec_h = {bus_h.mem_req, bus_h.mem_we, bus_h.mem_addr_s, wir_h, wpc_h, pcs_h,
                   wreg_h, rds_h, wds_h, la_h, lb_h, lc_h, lf_h, ld_h, halt_h};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [2:0] cls, input logic cp, input logic sb,
                      input logic wb, input logic rdy);
      ins_class = cls;
      cond_pass = cp;
      s_bit     = sb;
      wb_base   = wb;
      mem_ready = rdy;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drv(DP, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      // Reset state
      chk("rst_out_a", 32'(vec_a), 32'(O_ZERO));
      chk("rst_out_h", 32'(vec_h), 32'(O_ZERO));
      chk("rst_trap", 32'(trap_a), 32'd0);
      chk("rst_cause", 32'(cause_a), 32'd0);
      chk("rst_cnt", cnt_a, 32'd0);

      // DP S=1, two wait cycles in FETCH
      rst = 1'b0;
      #1;
      chk("dp_fetch_w1", 32'(vec_a), 32'(O_FWAIT));
      tick();
      chk("dp_fetch_w2", 32'(vec_a), 32'(O_FWAIT));
      tick();
      drv(DP, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("dp_fetch_done", 32'(vec_a), 32'(O_FDONE));
      tick();
      drv(DP, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("dp_decode", 32'(vec_a), 32'(O_DEC));
      tick();
      chk("dp_exec", 32'(vec_a), 32'(O_EXDP_S));
      tick();
      chk("dp_wb", 32'(vec_a), 32'(O_WBALU));
      chk("dp_cnt_before", cnt_a, 32'd0);
      tick();
      chk("dp_back_fetch", 32'(vec_a), 32'(O_FWAIT));
      chk("dp_cnt", cnt_a, 32'd1);

      // STR with failed condition retires straight from DECODE
      drv(STR, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("nc_fetch", 32'(vec_a), 32'(O_FDONE));
      tick();
      chk("nc_decode", 32'(vec_a), 32'(O_DEC));
      tick();
      chk("nc_fetch2", 32'(vec_a), 32'(O_FDONE));
      chk("nc_cnt", cnt_a, 32'd2);

      // LDR with base writeback, memory always ready: 6 cycles
      drv(LDR, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      chk("ldr_decode", 32'(vec_a), 32'(O_DEC));
      tick();
      chk("ldr_addr", 32'(vec_a), 32'(O_EXC));
      tick();
      chk("ldr_memrd", 32'(vec_a), 32'(O_RDDONE));
      tick();
      chk("ldr_wbload", 32'(vec_a), 32'(O_WBLOAD));
      tick();
      chk("ldr_wbbase", 32'(vec_a), 32'(O_WBBASE));
      chk("ldr_cnt_before", cnt_a, 32'd2);
      tick();
      chk("ldr_fetch", 32'(vec_a), 32'(O_FDONE));
      chk("ldr_cnt", cnt_a, 32'd3);

      // BL
      drv(BL, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("bl_branch", 32'(vec_a), 32'(O_BR_BL));
      tick();
      chk("bl_fetch", 32'(vec_a), 32'(O_FDONE));
      chk("bl_cnt", cnt_a, 32'd4);

      // B
      drv(B, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("b_branch", 32'(vec_a), 32'(O_BR_B));
      tick();
      chk("b_cnt", cnt_a, 32'd5);

      // CMP with S=0 retires from EXEC_DP
      drv(CMP, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("cmp_exec", 32'(vec_a), 32'(O_EXC));
      tick();
      chk("cmp_fetch", 32'(vec_a), 32'(O_FDONE));
      chk("cmp_cnt", cnt_a, 32'd6);

      // STR without writeback, one memory wait cycle
      drv(STR, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("str_addr", 32'(vec_a), 32'(O_EXC));
      tick();
      drv(STR, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("str_wr1", 32'(vec_a), 32'(O_MWR));
      tick();
      chk("str_wr2", 32'(vec_a), 32'(O_MWR));
      drv(STR, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("str_wr3", 32'(vec_a), 32'(O_MWR));
      tick();
      chk("str_fetch", 32'(vec_a), 32'(O_FDONE));
      chk("str_cnt", cnt_a, 32'd7);

      // LDR: ready arrives in the cycle the wait count reaches the limit
      drv(LDR, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      drv(LDR, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lim_rd1", 32'(vec_a), 32'(O_RDWAIT));
      tick();
      tick();
      chk("lim_rd3", 32'(vec_a), 32'(O_RDWAIT));
      tick();
      drv(LDR, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("lim_rd4", 32'(vec_a), 32'(O_RDDONE));
      tick();
      chk("lim_wbload", 32'(vec_a), 32'(O_WBLOAD));
      tick();
      chk("lim_no_trap", 32'(trap_a), 32'd0);
      chk("lim_cnt", cnt_a, 32'd8);

      // Reset in the middle of a MEM_WR wait
      drv(STR, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
      tick();
      drv(STR, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("rstw_wr", 32'(vec_a), 32'(O_MWR));
      tick();
      rst = 1'b1;
      #1;
      chk("rstw_forced", 32'(vec_a), 32'(O_ZERO));
      tick();
      chk("rstw_req", 32'(bus_a.mem_req), 32'd0);
      chk("rstw_cnt", cnt_a, 32'd0);
      chk("rstw_trap", 32'(trap_a), 32'd0);
      rst = 1'b0;
      #1;
      chk("rstw_fetch", 32'(vec_a), 32'(O_FWAIT));

      // Fetch timeout after 4 stalled cycles
      tick();
      tick();
      tick();
      chk("to_fetch_w4", 32'(vec_h), 32'(O_FWAIT));
      tick();
      chk("to_trap_a", 32'(vec_a), 32'(O_TRAP));
      chk("to_trap_h", 32'(vec_h), 32'(O_TRAP));
      chk("to_flag_h", 32'(trap_h), 32'd1);
      chk("to_cause_h", 32'(cause_h), 32'd1);
      chk("to_cause_a", 32'(cause_a), 32'd1);
      tick();
      chk("to_resume_a", 32'(vec_a), 32'(O_FWAIT));
      chk("to_halt_h", 32'(vec_h), 32'(O_HALT));

      // UND with a failed condition still traps; dut_h stays halted
      drv(UND, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("und_fetch_a", 32'(vec_a), 32'(O_FDONE));
      chk("und_halt_req_h", 32'(vec_h), 32'(O_HALT));
      tick();
      chk("und_decode_a", 32'(vec_a), 32'(O_DEC));
      tick();
      chk("und_trap_a", 32'(vec_a), 32'(O_TRAP));
      chk("und_cause_a", 32'(cause_a), 32'd2);
      tick();
      chk("und_resume_a", 32'(vec_a), 32'(O_FDONE));
      chk("und_sticky_a", 32'(trap_a), 32'd1);
      chk("und_cnt_a", cnt_a, 32'd0);
      chk("und_halt_h", 32'(vec_h), 32'(O_HALT));
      chk("und_cause_h", 32'(cause_h), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
